mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the multi-cycle MIPS datapath; parametrised successor of the single-cycle main opcode decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and emits per-state datapath controls.
- Adds a memory ready handshake with a timeout watchdog and a retired-instruction counter.
- Sits between the instruction register opcode field and the datapath muxes, register file, PC and memory port.

Parameters:
- WAIT_MAX, 15: max consecutive not-ready cycles tolerated in a memory state; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- opcode  in  6  IR[31:26]; stable from DECODE until the instruction retires (IR is written only in FETCH).
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_write  out  1  write request (qualifies mem_req).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  IR load enable.
- pc_write  out  1  unconditional PC write.
- branch  out  1  PC write conditional on ALU zero.
- branch_ne  out  1  PC write conditional on !zero.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm<<2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct.
- reg_write, reg_dest, mem_to_reg  out  1 each  register-file controls.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode.
- bus_err  out  1  sticky watchdog flag; cleared only by rst.
- instr_cnt  out  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.
- state  out  4  current state code, for debug.

Behaviour:
- State register, 4 bits. Encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- On rst:
  - state = FETCH; instr_cnt = 0; bus_err = 0; wait counter = 0.
  - Because controls decode from state, outputs after reset equal FETCH values.
- Reset mid-instruction aborts it: no instr_done pulse and no counter increment.
- Control outputs are combinational from state, plus mem_ready in the memory states. Any control not listed for a state is 0.
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=pc_write=mem_ready.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00.
  - MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_req=1, iord=1.
  - MEMWR: mem_req=1, iord=1, mem_write=1.
  - MEMWB: reg_write=1, reg_dest=0, mem_to_reg=1.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write=1, reg_dest=1.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1.
  - ADDIWB: reg_write=1, reg_dest=0.
  - JUMP: pc_src=10, pc_write=1.
- Transitions:
  - FETCH→DECODE on mem_ready; otherwise stay in FETCH.
  - DECODE branches on opcode:
    - 000000→EXEC.
    - 100011 or 101011→MEMADR.
    - 000100→BRANCH.
    - 001000→ADDIEX.
    - 000010→JUMP.
    - any other opcode→FETCH, with illegal_op=1 that cycle.
  - MEMADR→MEMRD if opcode 100011, else MEMWR.
  - MEMRD→MEMWB on mem_ready.
  - MEMWR→FETCH on mem_ready.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Retire:
  - instr_done=1 in MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, and in MEMWR when mem_ready=1.
  - instr_cnt increments at the same edge.
- Cycle counts with zero-wait memory: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each not-ready cycle adds 1.
- Watchdog (WAIT_MAX>0):
  - The counter clears on every state change and increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - When the counter equals WAIT_MAX-1 and mem_ready=0, the next edge forces state=FETCH and sets bus_err=1. No retire is counted.
  - mem_ready=1 in that same cycle wins: normal transition, no error.
  - A watchdog trip in FETCH re-enters FETCH; the counter clears.

Optional Feature:
- Macro CTRL_BNE_EN.
- Defined:
  - opcode 000101 in DECODE→BNE state, encoding 12.
  - BNE drives the same controls as BRANCH except branch=0 and branch_ne=1.
  - BNE→FETCH, retires, 3 cycles.
- Undefined:
  - 000101 is illegal: illegal_op pulse, return to FETCH.
  - branch_ne is tied to 0.

Test Plan:
- rst high 2 cycles with mem_ready=1 → state=0, instr_cnt=0, bus_err=0, mem_req=1, alu_src_b=01 immediately after reset.
- Zero-wait sequence R-type, lw, sw, beq, j, addi → state traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,8 / 0,1,11 / 0,1,9,10; instr_cnt=6 after 23 cycles; exactly 6 instr_done pulses.
- lw with mem_ready low 3 cycles in MEMRD → stays in state 3 for 4 cycles, then MEMWB with reg_write=1, mem_to_reg=1; bus_err stays 0.
- WAIT_MAX=15, mem_ready held 0 in MEMWR → after 15 cycles state=0 and bus_err=1, with no instr_done; bus_err persists until rst.
- opcode 111111 in DECODE → illegal_op pulse, next state FETCH, instr_cnt unchanged.
- opcode 000101: with CTRL_BNE_EN → state 12, branch_ne=1, retires; without it → illegal_op pulse and branch_ne=0.

Source files
------------

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the MIPS datapath/memory port.
// master = control unit (drives controls), slave = datapath side (drives opcode, mem_ready).
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_write;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             branch;
    logic             branch_ne;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             reg_dest;
    logic             mem_to_reg;
    logic             instr_done;
    logic             illegal_op;
    logic             bus_err;
    logic [CNT_W-1:0] instr_cnt;
    logic [3:0]       state;

    modport master (
        input  opcode, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_write, branch, branch_ne,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dest,
               mem_to_reg, instr_done, illegal_op, bus_err, instr_cnt, state
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_write, branch, branch_ne,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dest,
               mem_to_reg, instr_done, illegal_op, bus_err, instr_cnt, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback, counts retires.
// Controls decode combinationally from state (plus mem_ready in memory states); transitions take 1 cycle.
// Memory states stall on mem_ready=0; a WAIT_MAX watchdog aborts to FETCH with sticky bus_err. Optional BNE: CTRL_BNE_EN.
module mc_control_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    mc_control_fsm_if.master   bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
`ifdef CTRL_BNE_EN
        , BNE  = 4'd12
`endif
    } state_t;

    localparam int WW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             bus_err_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal;
    logic             waiting;
    logic             trip;
    logic             done;

    assign waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready;
    assign trip    = (WAIT_MAX != 0) && waiting && (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            FETCH:  if (bus.mem_ready) state_d = DECODE;
            DECODE: begin
                case (bus.opcode)
                    6'b000000:            state_d = EXEC;
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100:            state_d = BRANCH;
                    6'b001000:            state_d = ADDIEX;
                    6'b000010:            state_d = JUMP;
`ifdef CTRL_BNE_EN
                    6'b000101:            state_d = BNE;
`endif
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (bus.opcode == 6'b100011) ? MEMRD : MEMWR;
            MEMRD:  if (bus.mem_ready) state_d = MEMWB;
            MEMWR:  if (bus.mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
        // Watchdog overrides any stalled transition; a ready response in the same cycle never trips.
        if (trip) state_d = FETCH;
    end

    always_comb begin
        if (WAIT_MAX == 0 || trip || state_d != state_q) wait_d = '0;
        else if (waiting)                                 wait_d = wait_q + 1'b1;
        else                                              wait_d = wait_q;
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.branch_ne  = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.reg_dest   = 1'b0;
        bus.mem_to_reg = 1'b0;
        done           = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            DECODE: bus.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWR: begin
                bus.mem_req   = 1'b1;
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                done          = bus.mem_ready;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                done           = 1'b1;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dest  = 1'b1;
                done          = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.branch    = 1'b1;
                done          = 1'b1;
            end
`ifdef CTRL_BNE_EN
            BNE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.branch_ne = 1'b1;
                done          = 1'b1;
            end
`endif
            ADDIWB: begin
                bus.reg_write = 1'b1;
                done          = 1'b1;
            end
            JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (trip) bus_err_q <= 1'b1;
            if (done) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.instr_done = done;
    assign bus.illegal_op = illegal;
    assign bus.bus_err    = bus_err_q;
    assign bus.instr_cnt  = cnt_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: reset, zero-wait program, stalls, watchdog, illegal and BNE opcodes.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    mc_control_fsm_if #(.CNT_W(32)) bus ();

    mc_control_fsm #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
        checks++; if (bus.instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.instr_cnt); end
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus.bus_err); end
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL reset_mem_req got %b want 1", bus.mem_req); end
        checks++; if (bus.alu_src_b !== 2'b01) begin errors++; $display("FAIL reset_alu_src_b got %b want 01", bus.alu_src_b); end
        checks++; if (bus.ir_write !== 1'b1) begin errors++; $display("FAIL reset_ir_write got %b want 1", bus.ir_write); end
    endtask

    task automatic test_zero_wait();
        logic [5:0] ops [6];
        int         lens [6];
        logic [3:0] trace [23];
        int         idx;
        int         dones;
        ops   = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        lens  = '{4, 5, 4, 3, 3, 4};
        trace = '{4'd0, 4'd1, 4'd6, 4'd7,
                  4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                  4'd0, 4'd1, 4'd2, 4'd5,
                  4'd0, 4'd1, 4'd8,
                  4'd0, 4'd1, 4'd11,
                  4'd0, 4'd1, 4'd9, 4'd10};
        idx = 0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            bus.opcode = ops[i];
            for (int j = 0; j < lens[i]; j++) begin
                bus.mem_ready = 1'b1;
                #1;
                checks++;
                if (bus.state !== trace[idx]) begin
                    errors++;
                    $display("FAIL zw_trace[%0d] got %0d want %0d", idx, bus.state, trace[idx]);
                end
                if (trace[idx] == 4'd4) begin
                    checks++;
                    if (bus.mem_to_reg !== 1'b1 || bus.reg_write !== 1'b1) begin
                        errors++;
                        $display("FAIL zw_memwb_ctrl got m2r=%b rw=%b want 1 1", bus.mem_to_reg, bus.reg_write);
                    end
                end
                if (trace[idx] == 4'd8) begin
                    checks++;
                    if (bus.branch !== 1'b1 || bus.alu_op !== 2'b01 || bus.pc_src !== 2'b01) begin
                        errors++;
                        $display("FAIL zw_branch_ctrl got br=%b op=%b src=%b want 1 01 01", bus.branch, bus.alu_op, bus.pc_src);
                    end
                end
                if (trace[idx] == 4'd7) begin
                    checks++;
                    if (bus.reg_dest !== 1'b1 || bus.reg_write !== 1'b1) begin
                        errors++;
                        $display("FAIL zw_aluwb_ctrl got rd=%b rw=%b want 1 1", bus.reg_dest, bus.reg_write);
                    end
                end
                if (bus.instr_done === 1'b1) dones++;
                tick();
                idx++;
            end
        end
        exp_cnt = 6;
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL zw_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
        checks++; if (dones !== 6) begin errors++; $display("FAIL zw_done_pulses got %0d want 6", dones); end
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL zw_end_state got %0d want 0", bus.state); end
    endtask

    task automatic test_mem_wait();
        bus.opcode = 6'b100011;
        bus.mem_ready = 1'b0;
        #1;
        checks++; if (bus.state !== 4'd0 || bus.ir_write !== 1'b0) begin errors++; $display("FAIL fetch_stall got st=%0d irw=%b want 0 0", bus.state, bus.ir_write); end
        tick();
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL fetch_stall_hold got %0d want 0", bus.state); end
        tick();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            checks++;
            if (bus.state !== 4'd3 || bus.iord !== 1'b1) begin
                errors++;
                $display("FAIL memrd_wait[%0d] got st=%0d iord=%b want 3 1", k, bus.state, bus.iord);
            end
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.state !== 4'd4 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL memwb_after_wait got st=%0d rw=%b m2r=%b done=%b want 4 1 1 1", bus.state, bus.reg_write, bus.mem_to_reg, bus.instr_done);
        end
        tick();
        exp_cnt++;
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL wait_no_bus_err got %b want 0", bus.bus_err); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL wait_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_watchdog();
        int dones;
        dones = 0;
        bus.opcode = 6'b101011;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int k = 0; k < 15; k++) begin
            bus.mem_ready = 1'b0;
            #1;
            checks++;
            if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
                errors++;
                $display("FAIL memwr_stall[%0d] got st=%0d mw=%b want 5 1", k, bus.state, bus.mem_write);
            end
            if (bus.instr_done === 1'b1) dones++;
            tick();
        end
        bus.opcode = 6'b000010;
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL wd_state got %0d want 0", bus.state); end
        checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL wd_bus_err got %b want 1", bus.bus_err); end
        checks++; if (dones !== 0) begin errors++; $display("FAIL wd_done_pulses got %0d want 0", dones); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL wd_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
        tick();
        tick();
        #1;
        checks++; if (bus.state !== 4'd11 || bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10) begin
            errors++; $display("FAIL jump_ctrl got st=%0d pcw=%b src=%b want 11 1 10", bus.state, bus.pc_write, bus.pc_src);
        end
        tick();
        exp_cnt++;
        checks++; if (bus.bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky got %b want 1", bus.bus_err); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL after_wd_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        bus.opcode = 6'b111111;
        bus.mem_ready = 1'b1;
        tick();
        #1;
        checks++; if (bus.state !== 4'd1 || bus.illegal_op !== 1'b1) begin errors++; $display("FAIL illegal_pulse got st=%0d ill=%b want 1 1", bus.state, bus.illegal_op); end
        tick();
        checks++; if (bus.state !== 4'd0 || bus.illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_next got st=%0d ill=%b want 0 0", bus.state, bus.illegal_op); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL illegal_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_bne();
        bus.opcode = 6'b000101;
        bus.mem_ready = 1'b1;
        tick();
        #1;
`ifdef CTRL_BNE_EN
        checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL bne_not_illegal got %b want 0", bus.illegal_op); end
        tick();
        checks++; if (bus.state !== 4'd12 || bus.branch_ne !== 1'b1 || bus.branch !== 1'b0 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL bne_state got st=%0d bne=%b br=%b done=%b want 12 1 0 1", bus.state, bus.branch_ne, bus.branch, bus.instr_done);
        end
        tick();
        exp_cnt++;
`else
        checks++; if (bus.illegal_op !== 1'b1 || bus.branch_ne !== 1'b0) begin errors++; $display("FAIL bne_illegal got ill=%b bne=%b want 1 0", bus.illegal_op, bus.branch_ne); end
        tick();
`endif
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL bne_end_state got %0d want 0", bus.state); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL bne_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        bus.opcode = 6'b100011;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        exp_cnt = 0;
        checks++; if (bus.state !== 4'd0) begin errors++; $display("FAIL rst_mid_state got %0d want 0", bus.state); end
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL rst_mid_bus_err got %b want 0", bus.bus_err); end
        checks++; if (bus.instr_cnt !== 32'(exp_cnt)) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", bus.instr_cnt); end
    endtask

    initial begin
        bus.opcode = 6'b000000;
        bus.mem_ready = 1'b0;
        test_reset();
        test_zero_wait();
        test_mem_wait();
        test_watchdog();
        test_illegal();
        test_bne();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
